// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg
// Shared types for the pipeline hazard controller: register address width,
// forwarding select encodings, FSM state encodings and the scoreboard record
// layout used for the EX/MEM/WB in-flight instruction records.
package hazard_ctrl_pkg;

  localparam int REG_ADDR_WIDTH = 5;

  typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t rd;
    reg_addr_t rs1;
    reg_addr_t rs2;
    logic      regwrite;
    logic      memread;
    logic      memwrite;
  } sb_rec_t;

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// hazard_fwd_unit
// Combinational forwarding compare for one EX operand.
// Ports:
//   ex_valid_i        EX record holds a real instruction
//   ex_rs_i           source register of this operand in EX
//   mem_valid_i/mem_regwrite_i/mem_memread_i/mem_rd_i  MEM producer fields
//   wb_valid_i/wb_regwrite_i/wb_rd_i                   WB producer fields
//   fwd_sel_o         FWD_RF / FWD_EXMEM / FWD_MEMWB
module hazard_fwd_unit
  import hazard_ctrl_pkg::*;
(
  input  logic      ex_valid_i,
  input  reg_addr_t ex_rs_i,
  input  logic      mem_valid_i,
  input  logic      mem_regwrite_i,
  input  logic      mem_memread_i,
  input  reg_addr_t mem_rd_i,
  input  logic      wb_valid_i,
  input  logic      wb_regwrite_i,
  input  reg_addr_t wb_rd_i,
  output fwd_sel_t  fwd_sel_o
);

  logic mem_hit;
  logic wb_hit;

  // A load in MEM has no data yet on the EX/MEM bus; load-use stalls cover it.
  assign mem_hit = mem_valid_i & mem_regwrite_i & ~mem_memread_i &
                   (mem_rd_i != '0) & (mem_rd_i == ex_rs_i);
  assign wb_hit  = wb_valid_i & wb_regwrite_i &
                   (wb_rd_i != '0) & (wb_rd_i == ex_rs_i);

  always_comb begin
    fwd_sel_o = FWD_RF;
    if (ex_valid_i) begin
      // Newest producer first.
      if (mem_hit) begin
        fwd_sel_o = FWD_EXMEM;
      end else if (wb_hit) begin
        fwd_sel_o = FWD_MEMWB;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
// Pipeline sequencing controller for the 5-stage core. Tracks EX/MEM/WB
// in-flight records and produces stall / bubble / flush / freeze controls and
// EX operand forwarding selects.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   id_valid, id_rs1_addr, id_rs2_addr, id_rd_addr,
//   id_regwrite, id_memread, id_memwrite   decoded ID instruction
//   ex_branch_taken                EX resolved a taken branch/jump
//   mem_ready                      data memory finished the MEM access
//   stall_if, stall_id             hold PC+IF/ID, hold ID
//   bubble_ex                      load NOP into ID/EX
//   flush_id                       clear IF/ID
//   freeze                         hold every pipeline register
//   fwd_a, fwd_b                   EX operand selects (00 RF, 01 EX/MEM, 10 MEM/WB)
//
// state    | meaning
// ST_RUN   | normal issue; load-use stalls allowed
// ST_FLUSH | remaining post-branch cycles with flush_id held high
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd_addr,
  input  logic                      id_regwrite,
  input  logic                      id_memread,
  input  logic                      id_memwrite,
  input  logic                      ex_branch_taken,
  input  logic                      mem_ready,
  output logic                      stall_if,
  output logic                      stall_id,
  output logic                      bubble_ex,
  output logic                      flush_id,
  output logic                      freeze,
  output logic [1:0]                fwd_a,
  output logic [1:0]                fwd_b
);

  localparam logic [1:0] CNT_RELOAD = 2'(FLUSH_CYCLES - 1);

  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  sb_rec_t    ex_q, ex_d;
  sb_rec_t    mem_q, mem_d;
  sb_rec_t    wb_q, wb_d;

  logic    taken;
  logic    luh;
  logic    luh_stall;
  sb_rec_t id_rec;

  always_comb begin
    id_rec.valid    = id_valid;
    id_rec.rd       = id_rd_addr;
    id_rec.rs1      = id_rs1_addr;
    id_rec.rs2      = id_rs2_addr;
    id_rec.regwrite = id_regwrite;
    id_rec.memread  = id_memread;
    id_rec.memwrite = id_memwrite;
  end

  always_comb begin
    freeze    = mem_q.valid & (mem_q.memread | mem_q.memwrite) & ~mem_ready;
    // A branch seen during freeze waits: EX holds it asserted until then.
    taken     = ex_branch_taken & ~freeze;
    flush_id  = taken | (state_q == ST_FLUSH);
    luh       = id_valid & ex_q.valid & ex_q.memread & (ex_q.rd != '0) &
                ((ex_q.rd == id_rs1_addr) | (ex_q.rd == id_rs2_addr));
    // The ID instruction is being flushed anyway, so no load-use stall then.
    luh_stall = luh & ~freeze & ~flush_id;
    stall_if  = freeze | luh_stall;
    stall_id  = freeze | luh_stall;
    bubble_ex = ~freeze & (taken | luh_stall);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!freeze) begin
      if (taken) begin
        // The taken cycle already counts as one flush cycle.
        if (FLUSH_CYCLES > 1) begin
          state_d = ST_FLUSH;
          cnt_d   = CNT_RELOAD;
        end else begin
          state_d = ST_RUN;
          cnt_d   = 2'd0;
        end
      end else if (state_q == ST_FLUSH) begin
        if (cnt_q <= 2'd1) begin
          state_d = ST_RUN;
          cnt_d   = 2'd0;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
    end
  end

  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (!freeze) begin
      ex_d  = (flush_id | bubble_ex) ? '0 : id_rec;
      mem_d = ex_q;
      wb_d  = mem_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= 2'd0;
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
    end
  end

  fwd_sel_t fwd_a_sel;
  fwd_sel_t fwd_b_sel;

  hazard_fwd_unit u_fwd_a (
    .ex_valid_i     (ex_q.valid),
    .ex_rs_i        (ex_q.rs1),
    .mem_valid_i    (mem_q.valid),
    .mem_regwrite_i (mem_q.regwrite),
    .mem_memread_i  (mem_q.memread),
    .mem_rd_i       (mem_q.rd),
    .wb_valid_i     (wb_q.valid),
    .wb_regwrite_i  (wb_q.regwrite),
    .wb_rd_i        (wb_q.rd),
    .fwd_sel_o      (fwd_a_sel)
  );

  hazard_fwd_unit u_fwd_b (
    .ex_valid_i     (ex_q.valid),
    .ex_rs_i        (ex_q.rs2),
    .mem_valid_i    (mem_q.valid),
    .mem_regwrite_i (mem_q.regwrite),
    .mem_memread_i  (mem_q.memread),
    .mem_rd_i       (mem_q.rd),
    .wb_valid_i     (wb_q.valid),
    .wb_regwrite_i  (wb_q.regwrite),
    .wb_rd_i        (wb_q.rd),
    .fwd_sel_o      (fwd_b_sel)
  );

  assign fwd_a = fwd_a_sel;
  assign fwd_b = fwd_b_sel;

endmodule
